// File: rtl/gsram_result_reader_if.sv
// ---------------------------------------------------------------------------
// gsram_result_reader_if
//
// Groups every signal of the result reader except clock and reset:
//   - command:      start (in), busy / done (out)
//   - gSRAM port:   rd_en, rd_row, rd_col (out), rdata (in, signed Q8.8,
//                   valid the cycle after rd_en)
//   - result stream: out_valid / out_ready handshake carrying out_data
//                   (signed Q8.8), out_row, out_col, out_last
//   - classification: class_valid pulse with class_row, class_idx, class_max
//
// The master modport is the reader itself; the slave modport is the
// surrounding system (gSRAM, host interface, controller).
// ---------------------------------------------------------------------------
interface gsram_result_reader_if;
  logic               start;
  logic               busy;
  logic               done;

  logic               rd_en;
  logic        [3:0]  rd_row;
  logic        [3:0]  rd_col;
  logic signed [15:0] rdata;

  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic        [3:0]  out_row;
  logic        [3:0]  out_col;
  logic               out_last;

  logic               class_valid;
  logic        [3:0]  class_row;
  logic        [3:0]  class_idx;
  logic signed [15:0] class_max;

  modport master (
    input  start,
    output busy, done,
    output rd_en, rd_row, rd_col,
    input  rdata,
    output out_valid,
    input  out_ready,
    output out_data, out_row, out_col, out_last,
    output class_valid, class_row, class_idx, class_max
  );

  modport slave (
    output start,
    input  busy, done,
    input  rd_en, rd_row, rd_col,
    output rdata,
    input  out_valid,
    output out_ready,
    input  out_data, out_row, out_col, out_last,
    input  class_valid, class_row, class_idx, class_max
  );
endinterface

// File: rtl/gsram_result_reader.sv
// ---------------------------------------------------------------------------
// gsram_result_reader
//
// Read side of the gSRAM answer buffer. A start pulse launches a row-major
// sweep over NUM_ROWS x NUM_COLS signed Q8.8 entries. Each entry is fetched
// (ISSUE), registered (CAPTURE) and offered on a valid/ready stream
// (PRESENT), so one element leaves at most every three cycles. While the
// sweep runs, a per-row signed argmax is tracked and reported with a
// one-cycle class_valid pulse once the last column of a row is accepted.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-low reset; aborts any sweep
//   bus    - gsram_result_reader_if.master (command, gSRAM read port,
//            result stream, classification result)
//
// Parameters:
//   NUM_ROWS - rows swept, 1..16
//   NUM_COLS - columns per row (one per output class), 1..16
// ---------------------------------------------------------------------------
module gsram_result_reader #(
  parameter int NUM_ROWS = 4,
  parameter int NUM_COLS = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  gsram_result_reader_if.master  bus
);

  localparam int          DATA_W   = 16;
  localparam logic [3:0]  LAST_ROW = 4'(NUM_ROWS - 1);
  localparam logic [3:0]  LAST_COL = 4'(NUM_COLS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    PRESENT
  } state_t;

  // Strict signed comparison: ties keep the earlier (lower) column.
  function automatic logic is_greater(input logic signed [DATA_W-1:0] a,
                                      input logic signed [DATA_W-1:0] b);
    return a > b;
  endfunction

  state_t                    state;
  state_t                    next_state;

  // Sweep position of the element currently in flight.
  logic        [3:0]         row;
  logic        [3:0]         col;
  logic        [3:0]         row_nxt;
  logic        [3:0]         col_nxt;
  logic                      row_end;

  logic                      accept_start;
  logic                      do_capture;
  logic                      xfer;

  logic                      busy_q;
  logic                      done_q;
  logic        [3:0]         rd_row_q;
  logic        [3:0]         rd_col_q;

  logic signed [DATA_W-1:0]  out_data_q;
  logic        [3:0]         out_row_q;
  logic        [3:0]         out_col_q;
  logic                      out_last_q;

  // Running argmax of the current row.
  logic signed [DATA_W-1:0]  run_max;
  logic        [3:0]         run_idx;

  logic                      class_valid_q;
  logic        [3:0]         class_row_q;
  logic        [3:0]         class_idx_q;
  logic signed [DATA_W-1:0]  class_max_q;

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state and per-cycle strobes
  // -------------------------------------------------------------------------
  always_comb begin
    next_state   = state;
    accept_start = 1'b0;
    do_capture   = 1'b0;
    xfer         = 1'b0;
    unique case (state)
      IDLE: begin
        // start is only honoured here, so a pulse during a sweep is dropped.
        if (bus.start) begin
          accept_start = 1'b1;
          next_state   = ISSUE;
        end
      end
      ISSUE: begin
        next_state = CAPTURE;
      end
      CAPTURE: begin
        do_capture = 1'b1;
        next_state = PRESENT;
      end
      PRESENT: begin
        if (bus.out_ready) begin
          xfer       = 1'b1;
          next_state = out_last_q ? IDLE : ISSUE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Position of the next element once the current one has been accepted.
  always_comb begin
    row_end = (col == LAST_COL);
    row_nxt = row;
    col_nxt = col + 4'd1;
    if (row_end) begin
      row_nxt = row + 4'd1;
      col_nxt = 4'd0;
    end
  end

  // -------------------------------------------------------------------------
  // Sweep counters, gSRAM address, output stream and argmax registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row           <= '0;
      col           <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_row_q      <= '0;
      rd_col_q      <= '0;
      out_data_q    <= '0;
      out_row_q     <= '0;
      out_col_q     <= '0;
      out_last_q    <= 1'b0;
      run_max       <= '0;
      run_idx       <= '0;
      class_valid_q <= 1'b0;
      class_row_q   <= '0;
      class_idx_q   <= '0;
      class_max_q   <= '0;
    end else begin
      done_q        <= 1'b0;
      class_valid_q <= 1'b0;

      if (accept_start) begin
        busy_q   <= 1'b1;
        row      <= '0;
        col      <= '0;
        rd_row_q <= '0;
        rd_col_q <= '0;
      end

      // rdata answers the read issued in the previous (ISSUE) cycle.
      if (do_capture) begin
        out_data_q <= bus.rdata;
        out_row_q  <= row;
        out_col_q  <= col;
        out_last_q <= (row == LAST_ROW) && (col == LAST_COL);
        if ((col == 4'd0) || is_greater(bus.rdata, run_max)) begin
          run_max <= bus.rdata;
          run_idx <= col;
        end
      end

      if (xfer) begin
        row <= row_nxt;
        col <= col_nxt;
        if (row_end) begin
          class_valid_q <= 1'b1;
          class_row_q   <= row;
          class_idx_q   <= run_idx;
          class_max_q   <= run_max;
        end
        if (out_last_q) begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end else begin
          // Address is only moved when another read follows, so it holds
          // its last value whenever rd_en is low.
          rd_row_q <= row_nxt;
          rd_col_q <= col_nxt;
        end
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rd_en       = (state == ISSUE);
  assign bus.rd_row      = rd_row_q;
  assign bus.rd_col      = rd_col_q;
  assign bus.out_valid   = (state == PRESENT);
  assign bus.out_data    = out_data_q;
  assign bus.out_row     = out_row_q;
  assign bus.out_col     = out_col_q;
  assign bus.out_last    = out_last_q;
  assign bus.class_valid = class_valid_q;
  assign bus.class_row   = class_row_q;
  assign bus.class_idx   = class_idx_q;
  assign bus.class_max   = class_max_q;

endmodule

// File: doc/gsram_result_reader.md
Name: gsram_result_reader

Overview:
- Read-side counterpart to the gSRAM answer buffer. The answer buffer is written by the layer-2 MAC and sigmoid path.
- After a start pulse, sweeps the buffer row by row and presents each 16-bit Q8.8 entry on a valid/ready output stream.
- Computes a per-row signed argmax (classification result) on the fly.
- Sits between gSRAM and the off-chip or host result interface. It owns the gSRAM read port only while busy.

Parameters:
- NUM_ROWS, 4, rows swept (1..16).
- NUM_COLS, 10, columns per row (1..16); one column per output class.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a sweep; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the final element is accepted.
- rd_en  out  1  gSRAM read strobe; also the gSRAM address-mux select for the reader.
- rd_row  out  4  gSRAM row address.
- rd_col  out  4  gSRAM column address.
- rdata  in  16  gSRAM read data, signed Q8.8, valid exactly one cycle after rd_en.
- out_valid  out  1  stream data valid.
- out_ready  in  1  stream consumer ready.
- out_data  out  16  entry value, signed Q8.8.
- out_row  out  4  row of out_data.
- out_col  out  4  column of out_data.
- out_last  out  1  marks the final element of the sweep.
- class_valid  out  1  one-cycle pulse: row argmax result is valid.
- class_row  out  4  row the result belongs to.
- class_idx  out  4  column index of the row maximum.
- class_max  out  16  signed maximum value.

Behaviour:
- Reset: all outputs 0; FSM enters IDLE; row and column counters 0; running max cleared.
- FSM states: IDLE, ISSUE, CAPTURE, PRESENT.
- IDLE:
  - On start, zero row/col, go to ISSUE.
  - busy goes to 1 on the same edge.
- ISSUE (1 cycle):
  - rd_en=1 with rd_row/rd_col set to the current counters.
  - Go to CAPTURE.
  - rd_en is 0 in every other state.
  - rd_row/rd_col hold their last value when rd_en=0.
- CAPTURE (1 cycle):
  - Register rdata into out_data; register out_row/out_col from the counters.
  - out_last = (row==NUM_ROWS-1 && col==NUM_COLS-1).
  - Update argmax:
    - If col==0: max=rdata, idx=0.
    - Otherwise replace only if rdata > max (signed, strict). Ties therefore keep the lowest index.
  - Go to PRESENT.
- PRESENT:
  - out_valid=1.
  - out_data/out_row/out_col/out_last are held stable while out_valid && !out_ready.
  - Transfer occurs on a cycle with out_valid && out_ready. On the next edge out_valid drops to 0.
  - If col==NUM_COLS-1 at transfer:
    - class_valid pulses for one cycle (the following cycle) with class_row=row, class_idx, class_max.
    - col wraps to 0 and row increments.
  - Otherwise col increments.
  - After the final transfer (out_last): done pulses for one cycle, busy clears, FSM returns to IDLE.
  - Otherwise the FSM returns to ISSUE.
- Throughput: 3 cycles per element minimum (ISSUE, CAPTURE, PRESENT with ready high).
- Latency from start to the first out_valid is 3 cycles.
- start while busy has no effect, including start coinciding with the final transfer. A new start is accepted only in IDLE.
- out_ready is ignored when out_valid=0.
- Reset mid-sweep: the sweep is aborted immediately.
  - Outputs return to reset values.
  - No done or class_valid pulse is emitted.
- class_* hold their last values between pulses. They are cleared only by reset.
- NUM_ROWS=1 and NUM_COLS=1 are legal. With NUM_COLS=1, every element is a row maximum with idx 0.

Test Plan:
1. Reset values: assert reset=0 with start=1 and out_ready=1 -> all outputs 0, rd_en=0, FSM in IDLE. Release reset -> still idle until a start pulse.
2. Full sweep, ready tied high: preload gSRAM[r][c] = {r,c,8'h00}, NUM_ROWS=4, NUM_COLS=10.
   - 40 transfers in row-major order, one every 3 cycles; first out_valid 3 cycles after start.
   - out_last only on (3,9).
   - 4 class_valid pulses, each idx=9.
   - done exactly once, 1 cycle after the last transfer.
3. Backpressure: hold out_ready=0 for 5 cycles on element (1,2) -> out_valid, data, row and col stable; no rd_en issued. Release -> transfer, then ISSUE for (1,3).
4. Argmax: row 0 = {-3.0, 0x0100, 0x0100, 0x7FFF, 0x7FFF, 0x8000...}; row 1 all 0xFF00 (negative).
   - Row 0 -> class_idx=3, class_max=0x7FFF.
   - Row 1 -> class_idx=0, class_max=0xFF00 (tie keeps lowest index; signed compare).
5. start pulsed mid-sweep and on the final-transfer cycle -> no restart, single done. A start 1 cycle after done -> new sweep begins normally.
6. Reset asserted while in PRESENT for (2,5) -> immediate return to IDLE with zeroed outputs and no done pulse. A subsequent start sweeps from (0,0).
